bit_serial_adder_ctrl: RTL and testbench
========================================

// Module: bit_serial_adder_ctrl
// PURPOSE
//  Sequences one full_adder cell over WIDTH clock cycles to add two WIDTH-bit operands bit-serially, LSB first.
//  Operands enter on a valid/ready input channel; the result leaves on a valid/ready output channel.
//  Area-minimal alternative to a ripple/parallel adder in the arithmetic datapath.
// PARAMETERS
//  WIDTH  8  operand/result width in bits; legal range >= 1
// PORTS
//  clk      in   1      single clock, rising edge
//  rst      in   1      synchronous, active-high reset
//  s_valid  in   1      operand request valid
//  s_ready  out  1      block can accept operands
//  s_a      in   WIDTH  operand A
//  s_b      in   WIDTH  operand B
//  s_ci     in   1      carry-in
//  m_valid  out  1      result valid
//  m_ready  in   1      downstream accepts result
//  m_sum    out  WIDTH  sum (A+B+ci) mod 2^WIDTH
//  m_co     out  1      carry-out of MSB
//  busy     out  1      high in RUN or DONE
// BEHAVIOUR
//  - Reset: state=IDLE, cnt=0, shift regs=0, m_sum=0, m_co=0, m_valid=0, busy=0; s_ready=0 while rst=1.
//  - Rst mid-operation: op abandoned and result discarded; IDLE on the next cycle.
//  - s_ready = (state==IDLE) & ~rst; m_valid = (state==DONE); all outputs registered or decoded from state.
//  - FSM IDLE -> RUN: on s_valid&s_ready, latch a_sh=s_a, b_sh=s_b, carry=s_ci, cnt=0.
//  - RUN, each cycle: full_adder(a_sh[0], b_sh[0], carry) -> sum bit shifted into sum_sh MSB.
//    a_sh/b_sh shift right; carry<=co; cnt++.
//  - RUN -> DONE: on the edge where cnt==WIDTH-1; m_sum<=final sum_sh, m_co<=co at the same edge.
//  - DONE: m_valid=1; m_sum/m_co held stable until m_valid&m_ready. On handshake -> IDLE; m_valid drops the next cycle.
//  - Latency: m_valid rises WIDTH+1 edges after the accepting edge. Minimum initiation interval is WIDTH+2 cycles.
//  - s_valid during RUN/DONE is ignored (s_ready=0); the requester must hold its operands.
//  - m_ready asserted outside DONE has no effect. m_sum/m_co keep the last result in IDLE/RUN.
//  - WIDTH=1: RUN lasts exactly one cycle. cnt width = $clog2(WIDTH+1).
// CONFIGURATION
//  BIT_SERIAL_ADD_OVF_EN defined:
//    - adds output m_ovf (out, 1) = signed two's-complement overflow, i.e. carry into MSB XOR m_co.
//    - carry into MSB is captured on the last RUN cycle; m_ovf registers alongside m_co.
//    - m_ovf resets to 0 and holds with m_sum.
//  Macro undefined: port and logic absent; all other behaviour identical.
// STRUCTURE
//  - Package bit_serial_add_pkg holds:
//    - typedef enum logic [1:0] {IDLE, RUN, DONE} bsa_state_t
//    - function cnt_w(WIDTH) returning $clog2(WIDTH+1)
//  - One sub-module: instance u_fa of the team's full_adder cell (a, b, ci -> sum, co).
//  - All sequencing logic stays in this module.
// TESTING
//  - Reset: rst high for 2 cycles -> s_ready=0, m_valid=0, m_sum=0x00; after release, s_ready=1 next cycle.
//  - Carry wrap: WIDTH=8, a=0xFF, b=0x01, ci=0 -> m_sum=0x00, m_co=1, m_valid exactly 9 edges after accept;
//    with OVF_EN, m_ovf=0.
//  - Signed overflow: a=0x7F, b=0x01, ci=0 -> m_sum=0x80, m_co=0; m_ovf=1 with BIT_SERIAL_ADD_OVF_EN.
//    Second case a=0x12, b=0x34, ci=1 -> m_sum=0x47, m_co=0.
//  - Backpressure: hold m_ready=0 for 5 cycles in DONE -> m_sum/m_co stable, s_ready=0, new s_valid ignored;
//    release -> IDLE next cycle.
//  - Reset mid-RUN: assert rst at cnt=3 -> no m_valid ever for that op; next op a=0x05, b=0x03 -> m_sum=0x08.
//  - WIDTH=1 build: a=1, b=1, ci=1 -> m_sum=1, m_co=1, m_valid 2 edges after accept.
//    Random back-to-back ops are checked against a+b+ci.

Source files
------------

// File: rtl/bit_serial_add_pkg.sv
// Shared types and helpers for the bit-serial adder controller.
// The optional overflow output is enabled with BIT_SERIAL_ADD_OVF_EN.
package bit_serial_add_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } bsa_state_t;

  // Counter width able to hold 0..WIDTH.
  function automatic int cnt_w(input int width);
    return $clog2(width + 1);
  endfunction

endpackage

// File: rtl/full_adder.sv
// Single-bit full adder cell: a + b + ci -> {co, sum}.
module full_adder (
  input  logic a,
  input  logic b,
  input  logic ci,
  output logic sum,
  output logic co
);

  assign sum = a ^ b ^ ci;
  assign co  = (a & b) | (ci & (a ^ b));

endmodule

// File: rtl/bit_serial_adder_ctrl.sv
// Adds two WIDTH-bit operands LSB first through one full_adder over WIDTH RUN cycles.
// Define BIT_SERIAL_ADD_OVF_EN to add the signed-overflow output m_ovf.
module bit_serial_adder_ctrl
  import bit_serial_add_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             s_valid,
  output logic             s_ready,
  input  logic [WIDTH-1:0] s_a,
  input  logic [WIDTH-1:0] s_b,
  input  logic             s_ci,
  output logic             m_valid,
  input  logic             m_ready,
  output logic [WIDTH-1:0] m_sum,
  output logic             m_co,
`ifdef BIT_SERIAL_ADD_OVF_EN
  output logic             m_ovf,
`endif
  output logic             busy
);

  // Handshake: a transfer happens on a rising edge where valid and ready are both high;
  // s_ready is high only in IDLE and out of reset, m_valid only in DONE.

  localparam int CW = cnt_w(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  bsa_state_t       state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] a_sh_q, a_sh_d;
  logic [WIDTH-1:0] b_sh_q, b_sh_d;
  logic [WIDTH-1:0] sum_sh_q, sum_sh_d;
  logic [WIDTH-1:0] m_sum_q, m_sum_d;
  logic             carry_q, carry_d;
  logic             m_co_q, m_co_d;
  logic             ovf_q, ovf_d;
  logic             fa_sum, fa_co;

  full_adder u_fa (
    .a   (a_sh_q[0]),
    .b   (b_sh_q[0]),
    .ci  (carry_q),
    .sum (fa_sum),
    .co  (fa_co)
  );

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    a_sh_d   = a_sh_q;
    b_sh_d   = b_sh_q;
    sum_sh_d = sum_sh_q;
    carry_d  = carry_q;
    m_sum_d  = m_sum_q;
    m_co_d   = m_co_q;
    ovf_d    = ovf_q;
    case (state_q)
      IDLE: begin
        if (s_valid) begin
          a_sh_d  = s_a;
          b_sh_d  = s_b;
          carry_d = s_ci;
          cnt_d   = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        a_sh_d              = a_sh_q >> 1;
        b_sh_d              = b_sh_q >> 1;
        sum_sh_d            = sum_sh_q >> 1;
        sum_sh_d[WIDTH-1]   = fa_sum;
        carry_d             = fa_co;
        cnt_d               = cnt_q + CW'(1);
        if (cnt_q == LAST) begin
          // On the last bit carry_q is the carry into the MSB.
          m_sum_d = sum_sh_d;
          m_co_d  = fa_co;
          ovf_d   = carry_q ^ fa_co;
          state_d = DONE;
        end
      end
      DONE: begin
        if (m_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      a_sh_q   <= '0;
      b_sh_q   <= '0;
      sum_sh_q <= '0;
      carry_q  <= 1'b0;
      m_sum_q  <= '0;
      m_co_q   <= 1'b0;
      ovf_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      a_sh_q   <= a_sh_d;
      b_sh_q   <= b_sh_d;
      sum_sh_q <= sum_sh_d;
      carry_q  <= carry_d;
      m_sum_q  <= m_sum_d;
      m_co_q   <= m_co_d;
      ovf_q    <= ovf_d;
    end
  end

  assign s_ready = (state_q == IDLE) & ~rst;
  assign m_valid = (state_q == DONE);
  assign busy    = (state_q != IDLE);
  assign m_sum   = m_sum_q;
  assign m_co    = m_co_q;
`ifdef BIT_SERIAL_ADD_OVF_EN
  assign m_ovf   = ovf_q;
`else
  logic unused_ovf;
  assign unused_ovf = ovf_q;
`endif

endmodule

// File: tb/tb_bit_serial_adder_ctrl.sv
// Directed and table-driven bench for bit_serial_adder_ctrl (WIDTH=8 and WIDTH=1 instances).
module tb_bit_serial_adder_ctrl;

  localparam int WIDTH = 8;

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic       ci;
    logic [7:0] exp_sum;
    logic       exp_co;
    logic       exp_ovf;
  } vec_t;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             s_valid = 1'b0;
  logic             s_ready;
  logic [WIDTH-1:0] s_a = '0;
  logic [WIDTH-1:0] s_b = '0;
  logic             s_ci = 1'b0;
  logic             m_valid;
  logic             m_ready = 1'b0;
  logic [WIDTH-1:0] m_sum;
  logic             m_co;
  logic             m_ovf;
  logic             busy;

  logic       s_valid1 = 1'b0;
  logic       s_ready1;
  logic [0:0] s_a1 = '0;
  logic [0:0] s_b1 = '0;
  logic       s_ci1 = 1'b0;
  logic       m_valid1;
  logic       m_ready1 = 1'b0;
  logic [0:0] m_sum1;
  logic       m_co1;
  logic       m_ovf1;
  logic       busy1;

  int total = 0;
  int bad = 0;
  logic idle_ready = 1'b0;
  logic [WIDTH+1:0] exp_q[$];

  always #5 clk = ~clk;

  bit_serial_adder_ctrl #(.WIDTH(WIDTH)) u_dut (
    .clk(clk), .rst(rst), .s_valid(s_valid), .s_ready(s_ready),
    .s_a(s_a), .s_b(s_b), .s_ci(s_ci), .m_valid(m_valid), .m_ready(m_ready),
    .m_sum(m_sum), .m_co(m_co),
`ifdef BIT_SERIAL_ADD_OVF_EN
    .m_ovf(m_ovf),
`endif
    .busy(busy)
  );

  bit_serial_adder_ctrl #(.WIDTH(1)) u_dut1 (
    .clk(clk), .rst(rst), .s_valid(s_valid1), .s_ready(s_ready1),
    .s_a(s_a1), .s_b(s_b1), .s_ci(s_ci1), .m_valid(m_valid1), .m_ready(m_ready1),
    .m_sum(m_sum1), .m_co(m_co1),
`ifdef BIT_SERIAL_ADD_OVF_EN
    .m_ovf(m_ovf1),
`endif
    .busy(busy1)
  );

`ifndef BIT_SERIAL_ADD_OVF_EN
  assign m_ovf  = 1'b0;
  assign m_ovf1 = 1'b0;
`endif

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Drives one operand pair and collects the result, comparing against the scoreboard head.
  task automatic do_op(input logic [7:0] a, input logic [7:0] b, input logic ci,
                       input int hold, input string tag);
    int guard;
    int lat;
    logic [WIDTH+1:0] exp;
    logic [WIDTH-1:0] held_sum;
    logic held_co;
    guard = 0;
    while (!s_ready && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    check({tag, " s_ready"}, 32'(s_ready), 32'd1);
    s_a = a; s_b = b; s_ci = ci; s_valid = 1'b1;
    @(negedge clk);
    s_valid = 1'b0;
    lat = 1;
    check({tag, " busy"}, 32'(busy), 32'd1);
    while (!m_valid && lat < 50) begin
      @(negedge clk);
      lat++;
    end
    check({tag, " latency"}, 32'(lat), 32'(WIDTH + 1));
    if (hold > 0) begin
      held_sum = m_sum;
      held_co  = m_co;
      s_a = ~a; s_b = ~b; s_valid = 1'b1;
      for (int i = 0; i < hold; i++) begin
        @(negedge clk);
        check({tag, " hold valid"}, 32'(m_valid), 32'd1);
        check({tag, " hold s_ready"}, 32'(s_ready), 32'd0);
        check({tag, " hold stable"}, 32'({m_co, m_sum}), 32'({held_co, held_sum}));
      end
      s_valid = 1'b0;
    end
    if (exp_q.size() == 0) begin
      check({tag, " scoreboard empty"}, 32'd0, 32'd1);
    end else begin
      exp = exp_q.pop_front();
      check({tag, " sum"}, 32'(m_sum), 32'(exp[WIDTH-1:0]));
      check({tag, " co"}, 32'(m_co), 32'(exp[WIDTH]));
`ifdef BIT_SERIAL_ADD_OVF_EN
      check({tag, " ovf"}, 32'(m_ovf), 32'(exp[WIDTH+1]));
`endif
    end
    m_ready = 1'b1;
    @(negedge clk);
    m_ready = idle_ready;
    check({tag, " valid drop"}, 32'(m_valid), 32'd0);
    if (hold > 0) begin
      check({tag, " idle after release"}, 32'(s_ready), 32'd1);
      check({tag, " ignored op"}, 32'(busy), 32'd0);
    end
  endtask

  initial begin
    vec_t vecs[9];
    logic [8:0] s9;
    logic [7:0] ra, rb;
    logic rci;
    int lat;
    bit seen;

    vecs[0] = '{8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0};
    vecs[1] = '{8'h7F, 8'h01, 1'b0, 8'h80, 1'b0, 1'b1};
    vecs[2] = '{8'h12, 8'h34, 1'b1, 8'h47, 1'b0, 1'b0};
    vecs[3] = '{8'h00, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0};
    vecs[4] = '{8'h80, 8'h80, 1'b0, 8'h00, 1'b1, 1'b1};
    vecs[5] = '{8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1, 1'b0};
    vecs[6] = '{8'hA5, 8'h5A, 1'b0, 8'hFF, 1'b0, 1'b0};
    vecs[7] = '{8'h0F, 8'hF1, 1'b0, 8'h00, 1'b1, 1'b0};
    vecs[8] = '{8'h40, 8'h40, 1'b0, 8'h80, 1'b0, 1'b1};

    // Reset block
    rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("reset s_ready", 32'(s_ready), 32'd0);
    check("reset m_valid", 32'(m_valid), 32'd0);
    check("reset m_sum", 32'(m_sum), 32'h00);
    check("reset m_co", 32'(m_co), 32'd0);
    check("reset busy", 32'(busy), 32'd0);
    check("reset m_ovf", 32'(m_ovf), 32'd0);
    rst = 1'b0;
    @(negedge clk);
    check("release s_ready", 32'(s_ready), 32'd1);

    for (int i = 0; i < 9; i++) begin
      exp_q.push_back({vecs[i].exp_ovf, vecs[i].exp_co, vecs[i].exp_sum});
      do_op(vecs[i].a, vecs[i].b, vecs[i].ci, 0, $sformatf("vec%0d", i));
    end

    // Backpressure: result held for 5 cycles while new requests are ignored
    exp_q.push_back({1'b0, 1'b0, 8'h47});
    do_op(8'h12, 8'h34, 1'b1, 5, "backpressure");

    // Reset while RUN is at cnt=3
    s_a = 8'h33; s_b = 8'h44; s_ci = 1'b0; s_valid = 1'b1;
    @(negedge clk);
    s_valid = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("midrst m_valid", 32'(m_valid), 32'd0);
    check("midrst busy", 32'(busy), 32'd0);
    check("midrst m_sum", 32'(m_sum), 32'h00);
    check("midrst s_ready", 32'(s_ready), 32'd0);
    rst = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 15; i++) begin
      @(negedge clk);
      if (m_valid) seen = 1'b1;
    end
    check("midrst no result", 32'(seen), 32'd0);
    exp_q.push_back({1'b0, 1'b0, 8'h08});
    do_op(8'h05, 8'h03, 1'b0, 0, "after midrst");

    // WIDTH=1 instance
    s_a1 = 1'b1; s_b1 = 1'b1; s_ci1 = 1'b1;
    check("w1 s_ready", 32'(s_ready1), 32'd1);
    s_valid1 = 1'b1;
    @(negedge clk);
    s_valid1 = 1'b0;
    lat = 1;
    while (!m_valid1 && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    check("w1 latency", 32'(lat), 32'd2);
    check("w1 sum", 32'(m_sum1), 32'd1);
    check("w1 co", 32'(m_co1), 32'd1);
    check("w1 ovf", 32'(m_ovf1), 32'd0);
    m_ready1 = 1'b1;
    @(negedge clk);
    check("w1 valid drop", 32'(m_valid1), 32'd0);
    m_ready1 = 1'b0;

    // Random back-to-back with m_ready held high (no effect outside DONE)
    idle_ready = 1'b1;
    m_ready = 1'b1;
    for (int i = 0; i < 20; i++) begin
      ra  = 8'($urandom_range(0, 255));
      rb  = 8'($urandom_range(0, 255));
      rci = 1'($urandom_range(0, 1));
      s9  = {1'b0, ra} + {1'b0, rb} + {8'd0, rci};
      exp_q.push_back({(ra[7] == rb[7]) && (s9[7] != ra[7]), s9[8], s9[7:0]});
      do_op(ra, rb, rci, 0, $sformatf("rand%0d", i));
    end
    m_ready = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
